// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit feeding the datapath.
// Moore decode of the sequencer state and the instruction register.
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  alu_op,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_R3,
        C_MD,
        C_R2,
        C_HLT
    } op_class_t;

    state_t    state;
    state_t    next;
    op_class_t cls;

    logic [4:0]  opcode;
    logic [15:0] ra_hot;
    logic [15:0] rb_hot;
    logic [15:0] rc_hot;
    state_t      done_next;
    logic        unused_ir;

    assign opcode    = IR[31:27];
    assign ra_hot    = 16'd1 << IR[26:23];
    assign rb_hot    = 16'd1 << IR[22:19];
    assign rc_hot    = 16'd1 << IR[18:15];
    assign unused_ir = ^IR[14:0];

    // Where an instruction goes once its last state completes.
    assign done_next = Stop ? S_HALT : S_T0;

    // Classify the opcode; anything unrecognised behaves as a no-op.
    always_comb begin
        cls = C_NOP;
        case (opcode)
            5'd3, 5'd4, 5'd5,
            5'd6, 5'd7, 5'd8,
            5'd9, 5'd10, 5'd11: cls = C_R3;
            5'd15, 5'd16:       cls = C_MD;
            5'd17, 5'd18:       cls = C_R2;
            5'd27:              cls = C_HLT;
            default:            cls = C_NOP;
        endcase
    end

    // State register; Clear aborts anything in flight.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= S_RESET;
        end else begin
            state <= next;
        end
    end

    // Next-state logic. IR is only valid from T3 onward, so the
    // instruction class is resolved there rather than in T2.
    always_comb begin
        next = state;
        case (state)
            S_RESET: next = S_T0;
            S_T0:    next = S_T1;
            S_T1:    next = S_T2;
            S_T2:    next = S_T3;
            S_T3: begin
                case (cls)
                    C_R3:    next = S_T4;
                    C_MD:    next = S_T4;
                    C_R2:    next = S_T5;
                    C_HLT:   next = S_HALT;
                    default: next = done_next;
                endcase
            end
            S_T4:    next = S_T5;
            S_T5: begin
                if (cls == C_MD) begin
                    next = S_T6;
                end else begin
                    next = done_next;
                end
            end
            S_T6:    next = done_next;
            S_HALT:  next = S_HALT;
            default: next = S_RESET;
        endcase
    end

    // Control strobe decode; every strobe defaults low.
    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        alu_op   = 5'd0;
        reg_in   = 16'd0;
        reg_out  = 16'd0;
        Run      = 1'b0;
        case (state)
            S_T0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                case (cls)
                    C_R3: begin
                        reg_out = rb_hot;
                        Yin     = 1'b1;
                    end
                    C_MD: begin
                        reg_out = ra_hot;
                        Yin     = 1'b1;
                    end
                    C_R2: begin
                        reg_out = rb_hot;
                        alu_op  = opcode;
                        Zin     = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_T4: begin
                Run = 1'b1;
                case (cls)
                    C_R3: begin
                        reg_out = rc_hot;
                        alu_op  = opcode;
                        Zin     = 1'b1;
                    end
                    C_MD: begin
                        reg_out = rb_hot;
                        alu_op  = opcode;
                        Zin     = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_T5: begin
                Run = 1'b1;
                case (cls)
                    C_R3, C_R2: begin
                        Zlowout = 1'b1;
                        reg_in  = ra_hot;
                    end
                    C_MD: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_T6: begin
                Run = 1'b1;
                if (cls == C_MD) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer.
// Walks reset, each instruction class, Stop and mid-instruction Clear.
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic        IncPC, Read, Run;
    logic [4:0]  alu_op;
    logic [15:0] reg_in;
    logic [15:0] reg_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [16:0] K_PCOUT = 17'h10000;
    localparam logic [16:0] K_ZHI   = 17'h08000;
    localparam logic [16:0] K_ZLO   = 17'h04000;
    localparam logic [16:0] K_MDRO  = 17'h02000;
    localparam logic [16:0] K_MARIN = 17'h00400;
    localparam logic [16:0] K_ZIN   = 17'h00200;
    localparam logic [16:0] K_PCIN  = 17'h00100;
    localparam logic [16:0] K_MDRIN = 17'h00080;
    localparam logic [16:0] K_IRIN  = 17'h00040;
    localparam logic [16:0] K_YIN   = 17'h00020;
    localparam logic [16:0] K_HIIN  = 17'h00010;
    localparam logic [16:0] K_LOIN  = 17'h00008;
    localparam logic [16:0] K_INC   = 17'h00004;
    localparam logic [16:0] K_READ  = 17'h00002;
    localparam logic [16:0] K_RUN   = 17'h00001;

    localparam logic [16:0] K_T0 = K_RUN | K_PCOUT | K_MARIN | K_INC | K_ZIN;
    localparam logic [16:0] K_T1 = K_RUN | K_ZLO | K_PCIN | K_READ | K_MDRIN;
    localparam logic [16:0] K_T2 = K_RUN | K_MDRO | K_IRIN;

    logic [16:0] ctl;
    assign ctl = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
                  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
                  IncPC, Read, Run};

    control_sequencer dut (
        .Clock    (Clock),
        .Clear    (Clear),
        .IR       (IR),
        .Stop     (Stop),
        .PCout    (PCout),
        .Zhighout (Zhighout),
        .Zlowout  (Zlowout),
        .MDRout   (MDRout),
        .HIout    (HIout),
        .LOout    (LOout),
        .MARin    (MARin),
        .Zin      (Zin),
        .PCin     (PCin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .HIin     (HIin),
        .LOin     (LOin),
        .IncPC    (IncPC),
        .Read     (Read),
        .alu_op   (alu_op),
        .reg_in   (reg_in),
        .reg_out  (reg_out),
        .Run      (Run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [16:0] ectl,
                       input logic [4:0] ealu, input logic [15:0] ein,
                       input logic [15:0] eout);
        logic [53:0] obs;
        logic [53:0] exp;
        obs = {ctl, alu_op, reg_in, reg_out};
        exp = {ectl, ealu, ein, eout};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag);
        tick();
        chk({tag, "_t1"}, K_T1, 5'd0, 16'd0, 16'd0);
        tick();
        chk({tag, "_t2"}, K_T2, 5'd0, 16'd0, 16'd0);
    endtask

    task automatic restart();
        @(posedge Clock);
        #2;
        Clear = 1'b0;
        tick();
        chk("restart_t0", K_T0, 5'd0, 16'd0, 16'd0);
    endtask

    initial begin
        Clear = 1'b1;
        Stop  = 1'b0;
        IR    = 32'h0;
        #3;
        chk("reset_idle", 17'd0, 5'd0, 16'd0, 16'd0);
        tick();
        chk("reset_hold", 17'd0, 5'd0, 16'd0, 16'd0);
        Clear = 1'b0;
        tick();
        chk("first_t0", K_T0, 5'd0, 16'd0, 16'd0);

        // shra R1,R3,R5
        IR = 32'h409A8000;
        fetch("shra");
        tick();
        chk("shra_t3", K_RUN | K_YIN, 5'd0, 16'd0, 16'h0008);
        tick();
        chk("shra_t4", K_RUN | K_ZIN, 5'b01000, 16'd0, 16'h0020);
        tick();
        chk("shra_t5", K_RUN | K_ZLO, 5'd0, 16'h0002, 16'd0);
        tick();
        chk("shra_next", K_T0, 5'd0, 16'd0, 16'd0);

        // mul R6,R7
        IR = 32'h7B380000;
        fetch("mul");
        tick();
        chk("mul_t3", K_RUN | K_YIN, 5'd0, 16'd0, 16'h0040);
        tick();
        chk("mul_t4", K_RUN | K_ZIN, 5'b01111, 16'd0, 16'h0080);
        tick();
        chk("mul_t5", K_RUN | K_ZLO | K_LOIN, 5'd0, 16'd0, 16'd0);
        tick();
        chk("mul_t6", K_RUN | K_ZHI | K_HIIN, 5'd0, 16'd0, 16'd0);
        tick();
        chk("mul_next", K_T0, 5'd0, 16'd0, 16'd0);

        // neg R2,R4 skips T4 and T6
        IR = 32'h89200000;
        fetch("neg");
        tick();
        chk("neg_t3", K_RUN | K_ZIN, 5'b10001, 16'd0, 16'h0010);
        tick();
        chk("neg_t5", K_RUN | K_ZLO, 5'd0, 16'h0004, 16'd0);
        tick();
        chk("neg_next", K_T0, 5'd0, 16'd0, 16'd0);

        // add R1,R2,R3 with Stop pulsed only in T3
        IR = 32'h18918000;
        fetch("addp");
        tick();
        Stop = 1'b1;
        chk("addp_t3", K_RUN | K_YIN, 5'd0, 16'd0, 16'h0004);
        tick();
        Stop = 1'b0;
        chk("addp_t4", K_RUN | K_ZIN, 5'b00011, 16'd0, 16'h0008);
        tick();
        chk("addp_t5", K_RUN | K_ZLO, 5'd0, 16'h0002, 16'd0);
        tick();
        chk("addp_next", K_T0, 5'd0, 16'd0, 16'd0);

        // nop
        IR = 32'hD0000000;
        fetch("nop");
        tick();
        chk("nop_t3", K_RUN, 5'd0, 16'd0, 16'd0);
        tick();
        chk("nop_next", K_T0, 5'd0, 16'd0, 16'd0);

        // undefined opcode 0 behaves as nop
        IR = 32'h00000000;
        fetch("undef");
        tick();
        chk("undef_t3", K_RUN, 5'd0, 16'd0, 16'd0);
        tick();
        chk("undef_next", K_T0, 5'd0, 16'd0, 16'd0);

        // add aborted by Clear in T4
        IR = 32'h18918000;
        fetch("abrt");
        tick();
        chk("abrt_t3", K_RUN | K_YIN, 5'd0, 16'd0, 16'h0004);
        tick();
        chk("abrt_t4", K_RUN | K_ZIN, 5'b00011, 16'd0, 16'h0008);
        #2;
        Clear = 1'b1;
        #1;
        chk("abrt_clear", 17'd0, 5'd0, 16'd0, 16'd0);
        IR = 32'hD0000000;
        restart();
        fetch("abrt_re");
        tick();
        chk("abrt_re_t3", K_RUN, 5'd0, 16'd0, 16'd0);
        tick();
        chk("abrt_re_t0", K_T0, 5'd0, 16'd0, 16'd0);

        // Stop held across an add halts after T5
        IR   = 32'h18918000;
        Stop = 1'b1;
        fetch("adds");
        tick();
        chk("adds_t3", K_RUN | K_YIN, 5'd0, 16'd0, 16'h0004);
        tick();
        chk("adds_t4", K_RUN | K_ZIN, 5'b00011, 16'd0, 16'h0008);
        tick();
        chk("adds_t5", K_RUN | K_ZLO, 5'd0, 16'h0002, 16'd0);
        tick();
        Stop = 1'b0;
        chk("adds_halt", 17'd0, 5'd0, 16'd0, 16'd0);
        tick();
        chk("adds_halt2", 17'd0, 5'd0, 16'd0, 16'd0);
        Clear = 1'b1;
        #1;
        restart();

        // halt instruction
        IR = 32'hD8000000;
        fetch("hlt");
        tick();
        chk("hlt_t3", K_RUN, 5'd0, 16'd0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hlt_sticky", 17'd0, 5'd0, 16'd0, 16'd0);
        end
        Clear = 1'b1;
        #1;
        chk("hlt_clear", 17'd0, 5'd0, 16'd0, 16'd0);
        IR = 32'hD0000000;
        restart();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
